// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared constants for the FIFO write arbiter: FSM encoding, FIFO depth and
// default parameter values.
package fifo_arb_pkg;

  localparam int FIFO_DEPTH    = 16;
  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_BURST = 4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BURST   = 2'd1;
  localparam logic [1:0] ST_RD_SLOT = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    BURST   = ST_BURST,
    RD_SLOT = ST_RD_SLOT
  } state_e;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of producer, FIFO-strobe, consumer and grant-status signals around
// the arbiter. The slave modport is the arbiter; master is its environment.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  localparam int IDX_W  = $clog2(NUM_REQ)
) ();

  // Producer i transfers one beat on any clock edge where req_valid[i] and
  // req_ready[i] are both high; ready never depends on a future valid.
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      fifo_wr;
  logic [DATA_W-1:0]         fifo_din;
  logic                      fifo_rd;
  logic                      cons_rd_req;
  logic                      cons_rd_ack;
  logic [IDX_W-1:0]          grant_idx;
  logic                      grant_vld;

  modport slave (
    input  req_valid, req_data, fifo_full, fifo_empty, cons_rd_req,
    output req_ready, fifo_wr, fifo_din, fifo_rd, cons_rd_ack, grant_idx, grant_vld
  );

  modport master (
    output req_valid, req_data, fifo_full, fifo_empty, cons_rd_req,
    input  req_ready, fifo_wr, fifo_din, fifo_rd, cons_rd_ack, grant_idx, grant_vld
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: returns the first requesting index
// strictly after last_i, wrapping around NUM_REQ.
module rr_picker #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [IDX_W-1:0]   pick_o,
  output logic               any_o
);

  logic [IDX_W-1:0] idx;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    pick_o = '0;
    idx    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IDX_W'((int'(last_i) + k) % NUM_REQ);
      if (req_i[idx]) begin
        pick_o = idx;
      end
    end
    any_o = |req_i;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO among NUM_REQ producers and one
// consumer; it owns the FIFO strobes so writes and reads never collide.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic              clk,
  input  logic              rst,
  fifo_wr_arbiter_if.slave  bus,
  output logic [1:0]        state_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] beat_q, beat_d;

  logic [IDX_W-1:0]  pick;
  logic              any_req;
  logic              g_valid;
  logic [DATA_W-1:0] g_data;
  logic              in_burst;
  logic              wr_ok;
  logic              rd_ok;
  logic              burst_done;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i  (bus.req_valid),
    .last_i (last_q),
    .pick_o (pick),
    .any_o  (any_req)
  );

  assign in_burst   = (state_q == ST_BURST);
  assign g_valid    = bus.req_valid[grant_q];
  assign g_data     = bus.req_data[int'(grant_q)*DATA_W +: DATA_W];
  assign wr_ok      = in_burst & g_valid & ~bus.fifo_full;
  assign rd_ok      = (state_q == ST_IDLE || state_q == ST_RD_SLOT) &
                      bus.cons_rd_req & ~bus.fifo_empty;
  assign burst_done = wr_ok && (beat_q == CNT_W'(MAX_BURST - 1));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    beat_d  = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_d = pick;
          beat_d  = '0;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        if (wr_ok) beat_d = beat_q + CNT_W'(1);
        // A write this cycle means the FIFO will hold data for the read slot.
        if (burst_done || !g_valid || bus.fifo_full) begin
          last_d  = grant_q;
          state_d = (bus.cons_rd_req && (!bus.fifo_empty || wr_ok)) ? ST_RD_SLOT : ST_IDLE;
        end
      end
      ST_RD_SLOT: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (!rst && in_burst && !bus.fifo_full) bus.req_ready[grant_q] = 1'b1;
  end

  assign bus.fifo_wr     = ~rst & wr_ok;
  assign bus.fifo_rd     = ~rst & rd_ok;
  assign bus.cons_rd_ack = ~rst & rd_ok;
  assign bus.fifo_din    = (rst || !in_burst) ? '0 : g_data;
  assign bus.grant_vld   = ~rst & in_burst;
  assign bus.grant_idx   = rst ? '0 : grant_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a queue-based FIFO plus a transaction-level
// arbiter model predict every output each cycle; directed scenarios then random.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int NR    = 4;
  localparam int DW    = 8;
  localparam int MB    = 4;
  localparam int DEPTH = FIFO_DEPTH;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();
  logic [1:0] dbg_state;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (dbg_state)
  );

  // stimulus state
  logic [NR-1:0] v    = '0;
  logic [DW-1:0] d [NR];
  logic          cons = 1'b0;

  // reference model: FIFO contents plus arbitration bookkeeping
  logic [DW-1:0] exp_q[$];
  logic [1:0]    m_mode  = ST_IDLE;
  int            m_grant = 0;
  int            m_last  = NR - 1;
  int            m_beats = 0;

  int n_cmp = 0;
  int n_err = 0;
  int dut_wr_cnt = 0;
  int dut_rd_cnt = 0;
  logic       seen_vld = 1'b0;
  int         seen_gidx = 0;
  logic       prev_vld = 1'b0;
  int         gseq[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_ref(input logic [NR-1:0] r, input int last);
    for (int k = 1; k <= NR; k++) begin
      int idx;
      idx = (last + k) % NR;
      if (r[idx]) return idx;
    end
    return 0;
  endfunction

  // One clock cycle: drive inputs, predict and compare, then advance the model.
  task automatic step();
    logic          e_wr, e_rd, e_vld, full, empty;
    logic [NR-1:0] e_rdy;
    logic [DW-1:0] e_din;
    int            cnt;
    cnt   = exp_q.size();
    full  = (cnt == DEPTH);
    empty = (cnt == 0);
    bus.req_valid   = v;
    for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = d[i];
    bus.cons_rd_req = cons;
    bus.fifo_full   = full;
    bus.fifo_empty  = empty;
    #1;
    e_wr = 1'b0; e_rd = 1'b0; e_vld = 1'b0; e_rdy = '0; e_din = '0;
    if (!rst) begin
      if (m_mode == ST_BURST) begin
        e_vld = 1'b1;
        e_rdy[m_grant] = !full;
        e_wr  = v[m_grant] && !full;
        e_din = d[m_grant];
      end else begin
        e_rd = cons && !empty;
      end
    end
    chk("fifo_wr", bus.fifo_wr, e_wr);
    chk("fifo_rd", bus.fifo_rd, e_rd);
    chk("cons_rd_ack", bus.cons_rd_ack, e_rd);
    chk("req_ready", bus.req_ready, e_rdy);
    chk("grant_vld", bus.grant_vld, e_vld);
    chk("wr_rd_excl", bus.fifo_wr & bus.fifo_rd, 0);
    if (e_vld || rst) begin
      chk("fifo_din", bus.fifo_din, e_din);
      chk("grant_idx", bus.grant_idx, rst ? 0 : m_grant);
    end
    if (!rst) chk("state", dbg_state, m_mode);
    seen_vld  = bus.grant_vld;
    seen_gidx = int'(bus.grant_idx);
    if (bus.grant_vld && !prev_vld) gseq.push_back(int'(bus.grant_idx));
    prev_vld = bus.grant_vld;
    if (bus.fifo_wr) dut_wr_cnt++;
    if (bus.fifo_rd) dut_rd_cnt++;
    @(posedge clk);
    if (rst) begin
      m_mode = ST_IDLE; m_last = NR - 1; m_grant = 0; m_beats = 0;
      exp_q.delete();
    end else begin
      if (e_wr) exp_q.push_back(e_din);
      if (e_rd) void'(exp_q.pop_front());
      case (m_mode)
        ST_IDLE: if (v != '0) begin
          m_grant = rr_ref(v, m_last); m_beats = 0; m_mode = ST_BURST;
        end
        ST_BURST: begin
          if (e_wr) m_beats++;
          if ((e_wr && m_beats == MB) || !v[m_grant] || full) begin
            m_last = m_grant;
            m_mode = (cons && (!empty || e_wr)) ? ST_RD_SLOT : ST_IDLE;
          end
        end
        default: m_mode = ST_IDLE;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; v = '0; cons = 1'b0;
    step(); step();
    rst = 1'b0;
    dut_wr_cnt = 0; dut_rd_cnt = 0;
    gseq.delete();
  endtask

  task automatic preload(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(DW'($urandom));
  endtask

  task automatic wait_grant(input string tag, input int exp_idx);
    logic ok;
    int   g;
    ok = 1'b0; g = 99;
    for (int i = 0; i < 10 && !ok; i++) begin
      step();
      if (seen_vld) begin ok = 1'b1; g = seen_gidx; end
    end
    chk(tag, g, exp_idx);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) d[i] = DW'($urandom);
    @(negedge clk);

    // two producers alternate 4-beat bursts until the FIFO fills
    do_reset();
    d[0] = 8'hA0; d[2] = 8'hC2; v = 4'b0101;
    repeat (40) step();
    chk("s1_writes", dut_wr_cnt, 16);
    chk("s1_ready_full", bus.req_ready, 0);
    chk("s1_nbursts", gseq.size() >= 4, 1);
    for (int i = 0; i < 4 && i < gseq.size(); i++) chk("s1_order", gseq[i], (i % 2 == 0) ? 0 : 2);

    // short burst forfeits; round robin then prefers req3 over req1
    do_reset();
    v = 4'b0010; d[1] = 8'h11; d[3] = 8'h33;
    repeat (3) step();
    v = '0; step();
    chk("s2_writes", dut_wr_cnt, 2);
    v = 4'b1010;
    wait_grant("s2_grant", 3);
    v = '0; repeat (6) step();

    // read slots interleave with bursts; +2 entries per 6 cycles
    do_reset();
    preload(5);
    v = 4'b1000; cons = 1'b1;
    repeat (24) step();
    chk("s3_writes", dut_wr_cnt, 16);
    chk("s3_reads", dut_rd_cnt, 8);
    chk("s3_level", exp_q.size(), 13);

    // full FIFO: one consumer read admits exactly one more beat
    do_reset();
    preload(16);
    v = 4'b0001;
    repeat (4) step();
    for (int i = 0; i < 4 && m_mode != ST_IDLE; i++) step();
    dut_wr_cnt = 0; dut_rd_cnt = 0;
    cons = 1'b1; step(); cons = 1'b0;
    repeat (10) step();
    chk("s4_reads", dut_rd_cnt, 1);
    chk("s4_writes", dut_wr_cnt, 1);

    // reset mid-burst, then req0 wins over req2
    do_reset();
    v = 4'b0100;
    step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    v = 4'b0101;
    wait_grant("s5_grant", 0);
    v = '0; repeat (8) step();

    // empty FIFO never reads
    do_reset();
    cons = 1'b1;
    repeat (20) step();
    chk("s6_reads", dut_rd_cnt, 0);
    cons = 1'b0;

    // random traffic with occasional resets
    do_reset();
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NR; i++) begin
        if ($urandom_range(0, 3) == 0) v[i] = ~v[i];
        d[i] = DW'($urandom);
      end
      cons = 1'($urandom_range(0, 1));
      step();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares one 16-entry synchronous FIFO between NUM_REQ producers and one consumer.
- Grants write access round-robin, in bursts of at most MAX_BURST beats.
- Owns the FIFO wr/rd strobes so that writes and reads never collide; the FIFO gives write priority, so colliding reads would be dropped.
- Inserts a read slot after each burst so a waiting consumer is not starved.

Parameters:
- NUM_REQ, 4, number of producers (≥2)
- DATA_W, 8, data width; matches the FIFO din width
- MAX_BURST, 4, maximum accepted beats per grant (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  per-producer data valid
- req_data  in  NUM_REQ*DATA_W  per-producer data; slice i belongs to producer i
- req_ready  out  NUM_REQ  per-producer accept; a beat transfers when valid&ready
- fifo_full  in  1  FIFO full flag
- fifo_empty  in  1  FIFO empty flag
- fifo_wr  out  1  FIFO write strobe
- fifo_din  out  DATA_W  FIFO write data
- fifo_rd  out  1  FIFO read strobe
- cons_rd_req  in  1  consumer requests one read per cycle while high
- cons_rd_ack  out  1  equals fifo_rd; FIFO dout is valid the following cycle
- grant_idx  out  $clog2(NUM_REQ)  current grantee; meaningful when grant_vld=1
- grant_vld  out  1  high in BURST

Behaviour:
- FSM states: IDLE, BURST, RD_SLOT. Registers: state, grant_idx, last_grant, beat_cnt.
- Reset (rst=1 at an edge):
  - state=IDLE, last_grant=NUM_REQ-1, beat_cnt=0, grant_idx=0.
  - While rst is high, all outputs are forced to 0 (req_ready, fifo_wr, fifo_rd, cons_rd_ack, grant_vld; fifo_din=0).
  - Reset mid-burst abandons the burst. The FIFO shares rst.
- IDLE:
  - fifo_wr=0; req_ready=0.
  - fifo_rd = cons_rd_req & !fifo_empty.
  - If any req_valid: the round-robin pick is the first valid index after last_grant, wrapping modulo NUM_REQ. Register it into grant_idx, set beat_cnt=0, go to BURST.
  - Arbitration costs exactly one cycle; no write occurs in IDLE.
- BURST (g = grant_idx):
  - req_ready[g] = !fifo_full; all other ready bits are 0.
  - fifo_din = req_data[g].
  - fifo_wr = req_valid[g] & !fifo_full. This is combinational, with zero latency from the producer to the FIFO.
  - fifo_rd = 0.
  - On each write, beat_cnt increments.
  - Exit at the edge where any of the following holds: the write makes beat_cnt reach MAX_BURST; req_valid[g]=0 (no write that cycle); or fifo_full=1.
  - On exit: last_grant<=g. Next state is RD_SLOT if cons_rd_req=1 and (fifo_empty=0 or a write occurred this cycle); otherwise IDLE.
- RD_SLOT: exactly one cycle. fifo_wr=0; fifo_rd = cons_rd_req & !fifo_empty. Then go to IDLE.
- Invariants:
  - fifo_wr & fifo_full is never 1.
  - fifo_rd & fifo_empty is never 1.
  - fifo_wr & fifo_rd is never 1.
  - At most one req_ready bit is high.
  - grant_idx is stable throughout a burst.
- A producer dropping valid mid-burst forfeits the rest of its burst. Its next grant follows normal round-robin order.
- beat_cnt width is $clog2(MAX_BURST+1) and never exceeds MAX_BURST.

Decomposition:
- Package fifo_arb_pkg holds:
  - the state enum (IDLE, BURST, RD_SLOT)
  - FIFO_DEPTH=16
  - default DATA_W/NUM_REQ/MAX_BURST constants
- Sub-module rr_picker: purely combinational. Inputs are the req vector and last_grant. Outputs are pick index and any_req. It is unit-testable in isolation.

Test Plan:
- Reset, then req0 and req2 held valid with distinct data and cons_rd_req=0 → IDLE, 4 beats from req0, IDLE, 4 from req2, IDLE, 4 from req0, IDLE, 4 from req2. fifo_full rises after write 16; no further fifo_wr; req_ready=0 thereafter.
- Only req1 valid for 2 beats, then low → burst of 2 writes, exit to IDLE, last_grant=1. Next req1 and req3 both valid → req3 is granted first.
- FIFO holds 5 entries; req3 continuously valid; cons_rd_req=1 → repeating pattern of IDLE (1 read), BURST (4 writes), RD_SLOT (1 read). Net +2 entries per 6 cycles; fifo_wr and fifo_rd are never simultaneous.
- FIFO full (16); req0 valid; cons_rd_req pulsed for one cycle in IDLE → one read, full drops, next grant writes exactly 1 beat, full re-asserts, burst exits.
- rst asserted on the 2nd beat of a req2 burst → next cycle all outputs 0, state IDLE. After release with req0 and req2 valid, req0 is granted first (last_grant=3).
- FIFO empty, cons_rd_req=1, no producers → fifo_rd and cons_rd_ack stay 0 indefinitely.
